pb_field_tokenizer: RTL and testbench
=====================================

# pb_field_tokenizer

Streaming hardware front end for protobuf message decode. It accepts a raw wire-format byte stream at one byte per cycle and parses message keys, varints, fixed32/fixed64 values and length-delimited headers. It emits one token per decoded field, and one token per payload byte of length-delimited fields. It sits between the byte transport (DMA/FIFO) and the per-message field assemblers, and applies the same encoding rules as the software decode helpers in `pb_pkg`.

## Interface
Parameters:
- `MAX_LEN`, 65535: largest accepted length-delimited payload; larger lengths raise `ERR_LEN`.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block accepts the byte this cycle.
- `in_data`  in  8  wire byte.
- `in_last`  in  1  final byte of the message.
- `out_valid`  out  1  token valid.
- `out_ready`  in  1  downstream accepts the token.
- `out_kind`  out  2  `KIND_SCALAR`=0, `KIND_LEN_HDR`=1, `KIND_PAYLOAD`=2.
- `out_field`  out  29  field number.
- `out_wire`  out  3  wire type (0, 1, 2, 5).
- `out_value`  out  64  scalar value, length, or payload byte in [7:0] (upper bits 0).
- `out_last`  out  1  token produced by the `in_last` byte.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  3  last error: `ERR_NONE`=0, `ERR_VARINT_LONG`=1, `ERR_KEY`=2, `ERR_WIRE`=3, `ERR_LEN`=4, `ERR_TRUNC`=5.

## Operation
- FSM states: `ST_KEY`, `ST_VARINT`, `ST_FIX`, `ST_LEN`, `ST_PAYLOAD`, `ST_DRAIN`.
- **`ST_KEY`:** accumulates the key varint.
  - Maximum key length is 5 bytes; a 5th byte with bit7 set gives `ERR_KEY`.
  - On completion: field = key>>3 (29 bits), wire = key[2:0].
  - Field 0 gives `ERR_KEY`. Wire 3, 4, 6 or 7 gives `ERR_WIRE`.
  - Wire 0 → `ST_VARINT`. Wire 1 → `ST_FIX` with 8 bytes. Wire 5 → `ST_FIX` with 4 bytes. Wire 2 → `ST_LEN`.
- **Varint accumulation:** byte n (0-based) contributes bits [6:0] at shift 7n.
  - On the 10th byte only bit 0 is kept; higher bits are discarded.
  - A 10th byte with bit7 set gives `ERR_VARINT_LONG`.
- **`ST_VARINT`:** completion emits a `KIND_SCALAR` token with the zero-extended 64-bit value, then → `ST_KEY`.
- **`ST_FIX`:** bytes are assembled little-endian. After 4 or 8 bytes, emit `KIND_SCALAR` (fixed32 zero-extended), then → `ST_KEY`.
- **`ST_LEN`:** varint completes the length L.
  - L > `MAX_LEN` gives `ERR_LEN`.
  - Otherwise emit `KIND_LEN_HDR` with value L.
  - L=0 → `ST_KEY`; else → `ST_PAYLOAD` with remaining = L.
- **`ST_PAYLOAD`:** each byte emits a `KIND_PAYLOAD` token and decrements the counter. At 0 → `ST_KEY`. No nested decode.
- **`in_last` handling:**
  - `in_last` on a byte that completes a field, or on the final payload byte: normal token with `out_last`=1, then `ST_KEY`.
  - `in_last` anywhere else, including a `LEN_HDR` with L>0: `ERR_TRUNC`.
- **Errors:**
  - `err` pulses for one cycle. `err_code` updates and holds until the next error.
  - No token is emitted for the faulting field.
  - The block enters `ST_DRAIN`: `in_ready`=1 and bytes are discarded through the byte carrying `in_last`, then → `ST_KEY`.
  - If the faulting byte itself carries `in_last`, the block goes directly to `ST_KEY`.

## Timing
- **Reset values:** `out_valid`=0, `out_kind`/`out_field`/`out_wire`/`out_value`/`out_last`=0, `err`=0, `err_code`=0, state `ST_KEY`, accumulators 0.
- **`in_ready`:** combinational, = (`state`==`ST_DRAIN`) || !`out_valid` || `out_ready`. It is 0 while `rst_n`=0.
- **Output register:** single-entry. A token appears registered on the cycle after its completing byte is accepted (latency 1). Sustained throughput is 1 byte/cycle with `out_ready`=1.
- **Handshake:**
  - `out_*` stay stable while `out_valid` && !`out_ready`.
  - Input bytes that produce no token (key and varint continuation bytes) are still blocked by a stalled output register. This is intentional and keeps the logic simple.
- **Simultaneous events:** a token may be popped and a new one loaded in the same cycle.
- **`err` timing:** asserts the cycle after the faulting byte is accepted.
- **Reset mid-field:** all partial state is dropped; the next byte is treated as a key.

## Structure
- Shared package `pb_hw_pkg`:
  - `kind_e`, `err_e` and `state_e` typedefs.
  - Wire-type constants `WT_VARINT`=0, `WT_I64`=1, `WT_LEN`=2, `WT_I32`=5.
  - `MAX_VARINT_BYTES`=10 and `MAX_KEY_BYTES`=5.
- Sub-module `pb_varint_accum`:
  - Shift-accumulates one byte per enable.
  - Outputs `done`, `overflow` and `value[63:0]`.
  - Has a `clear` input and a byte limit.
  - Reused for key and value varints.

## Test plan
- 0x08 0x96 0x01 (last on 0x01) → SCALAR field 1, wire 0, value 150, `out_last`=1.
- 0x12 0x02 0x61 0x62 → LEN_HDR field 2 value 2, then PAYLOAD 0x61, then PAYLOAD 0x62 with `out_last`=1.
- 0x2D 0x01 0x02 0x03 0x04 → SCALAR field 5, wire 5, value 0x04030201. Follow with 0x08 0x01 → second token value 1 back-to-back.
- 0x08 followed by ten 0xFF bytes → `ERR_VARINT_LONG`, no token, drain to `in_last`. The next message decodes normally.
- 0x0B → `ERR_WIRE`. Separately, 0x12 0x05 0x61 (last) → `ERR_TRUNC`.
- Random `out_ready` toggling on a 3-field message → token sequence identical to the no-stall run, and no token lost or duplicated.

Source files
------------

// File: rtl/pb_hw_pkg.sv
// Shared types and wire-format constants for the protobuf field tokenizer.
// Kind, error and FSM state encodings live here so decode-side blocks agree on them.
package pb_hw_pkg;

    typedef enum logic [1:0] {
        KIND_SCALAR  = 2'd0,
        KIND_LEN_HDR = 2'd1,
        KIND_PAYLOAD = 2'd2
    } kind_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_VARINT_LONG = 3'd1,
        ERR_KEY         = 3'd2,
        ERR_WIRE        = 3'd3,
        ERR_LEN         = 3'd4,
        ERR_TRUNC       = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_KEY,
        ST_VARINT,
        ST_FIX,
        ST_LEN,
        ST_PAYLOAD,
        ST_DRAIN
    } state_e;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    localparam int unsigned MAX_VARINT_BYTES = 10;
    localparam int unsigned MAX_KEY_BYTES    = 5;

    function automatic logic wire_ok(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
    endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// Little-endian base-128 varint accumulator, one byte per enable.
// done/overflow/value describe the byte presented this cycle; state self-clears on either.
module pb_varint_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    input  logic [3:0]  limit,
    output logic        done,
    output logic        overflow,
    output logic [63:0] value
);

    logic [63:0] acc;
    logic [3:0]  count;
    logic [6:0]  shamt;

    // On the 10th byte the shift is 63, so bits [6:1] fall off the top.
    always_comb begin
        shamt    = 7'(count) * 7'd7;
        value    = acc | ({57'd0, data[6:0]} << shamt);
        done     = en && !data[7];
        overflow = en && data[7] && (count == limit - 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear || done || overflow) begin
            acc   <= '0;
            count <= '0;
        end else if (en) begin
            acc   <= value;
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/pb_field_tokenizer.sv
// Streaming protobuf wire-format tokenizer: one byte in per cycle, one token per
// scalar field, length header or payload byte, behind a single-entry output register.
module pb_field_tokenizer
    import pb_hw_pkg::*;
#(
    parameter int unsigned MAX_LEN = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [28:0] out_field,
    output logic [2:0]  out_wire,
    output logic [63:0] out_value,
    output logic        out_last,
    output logic        err,
    output logic [2:0]  err_code
);

    state_e      state, state_n;
    logic        accept;
    logic        va_en, va_clear, va_done, va_ovf;
    logic [3:0]  va_limit;
    logic [63:0] va_value;
    logic [28:0] key_field;
    logic [2:0]  key_wire;

    logic [28:0] field_q;
    logic [2:0]  wire_q;
    logic [63:0] fix_acc, fix_val;
    logic [2:0]  fix_idx, fix_end;
    logic [31:0] remaining;

    logic        tok_load, tok_last, err_fire;
    kind_e       tok_kind;
    logic [63:0] tok_value;
    err_e        err_code_n;
    logic        key_load, fix_step, len_load, pay_step;

    assign in_ready  = rst_n && ((state == ST_DRAIN) || !out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign key_field = va_value[31:3];
    assign key_wire  = va_value[2:0];
    assign fix_val   = fix_acc | ({56'd0, in_data} << {fix_idx, 3'b000});

    pb_varint_accum u_varint (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (va_clear),
        .en       (va_en),
        .data     (in_data),
        .limit    (va_limit),
        .done     (va_done),
        .overflow (va_ovf),
        .value    (va_value)
    );

    always_comb begin
        state_n    = state;
        tok_load   = 1'b0;
        tok_kind   = KIND_SCALAR;
        tok_value  = '0;
        tok_last   = in_last;
        err_fire   = 1'b0;
        err_code_n = ERR_NONE;
        key_load   = 1'b0;
        fix_step   = 1'b0;
        len_load   = 1'b0;
        pay_step   = 1'b0;
        va_en      = accept && ((state == ST_KEY) || (state == ST_VARINT) || (state == ST_LEN));
        va_limit   = (state == ST_KEY) ? 4'(MAX_KEY_BYTES) : 4'(MAX_VARINT_BYTES);

        if (accept) begin
            case (state)
                ST_KEY: begin
                    if (va_ovf || (va_done && key_field == '0)) begin
                        err_fire = 1'b1; err_code_n = ERR_KEY;
                    end else if (va_done && !wire_ok(key_wire)) begin
                        err_fire = 1'b1; err_code_n = ERR_WIRE;
                    end else if (in_last) begin
                        err_fire = 1'b1; err_code_n = ERR_TRUNC;
                    end else if (va_done) begin
                        key_load = 1'b1;
                        case (key_wire)
                            WT_VARINT: state_n = ST_VARINT;
                            WT_LEN:    state_n = ST_LEN;
                            default:   state_n = ST_FIX;
                        endcase
                    end
                end
                ST_VARINT: begin
                    if (va_ovf) begin
                        err_fire = 1'b1; err_code_n = ERR_VARINT_LONG;
                    end else if (va_done) begin
                        tok_load  = 1'b1;
                        tok_value = va_value;
                        state_n   = ST_KEY;
                    end else if (in_last) begin
                        err_fire = 1'b1; err_code_n = ERR_TRUNC;
                    end
                end
                ST_FIX: begin
                    if (fix_idx == fix_end) begin
                        tok_load  = 1'b1;
                        tok_value = fix_val;
                        state_n   = ST_KEY;
                    end else if (in_last) begin
                        err_fire = 1'b1; err_code_n = ERR_TRUNC;
                    end else begin
                        fix_step = 1'b1;
                    end
                end
                ST_LEN: begin
                    if (va_ovf) begin
                        err_fire = 1'b1; err_code_n = ERR_VARINT_LONG;
                    end else if (va_done && va_value > 64'(MAX_LEN)) begin
                        err_fire = 1'b1; err_code_n = ERR_LEN;
                    end else if (in_last && !(va_done && va_value == '0)) begin
                        err_fire = 1'b1; err_code_n = ERR_TRUNC;
                    end else if (va_done) begin
                        tok_load  = 1'b1;
                        tok_kind  = KIND_LEN_HDR;
                        tok_value = va_value;
                        len_load  = 1'b1;
                        state_n   = (va_value == '0) ? ST_KEY : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (remaining == 32'd1) begin
                        tok_load  = 1'b1;
                        tok_kind  = KIND_PAYLOAD;
                        tok_value = {56'd0, in_data};
                        pay_step  = 1'b1;
                        state_n   = ST_KEY;
                    end else if (in_last) begin
                        err_fire = 1'b1; err_code_n = ERR_TRUNC;
                    end else begin
                        tok_load  = 1'b1;
                        tok_kind  = KIND_PAYLOAD;
                        tok_value = {56'd0, in_data};
                        pay_step  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (in_last) state_n = ST_KEY;
                end
                default: state_n = ST_KEY;
            endcase
        end

        if (err_fire) state_n = in_last ? ST_KEY : ST_DRAIN;
        va_clear = err_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_KEY;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q   <= '0;
            wire_q    <= '0;
            fix_acc   <= '0;
            fix_idx   <= '0;
            fix_end   <= '0;
            remaining <= '0;
        end else begin
            if (key_load) begin
                field_q <= key_field;
                wire_q  <= key_wire;
                fix_acc <= '0;
                fix_idx <= '0;
                fix_end <= (key_wire == WT_I64) ? 3'd7 : 3'd3;
            end
            if (fix_step) begin
                fix_acc <= fix_val;
                fix_idx <= fix_idx + 3'd1;
            end
            if (len_load) remaining <= va_value[31:0];
            if (pay_step) remaining <= remaining - 32'd1;
        end
    end

    // Load may coincide with a pop; load wins and keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_field <= '0;
            out_wire  <= '0;
            out_value <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            if (tok_load) begin
                out_valid <= 1'b1;
                out_kind  <= tok_kind;
                out_field <= field_q;
                out_wire  <= wire_q;
                out_value <= tok_value;
                out_last  <= tok_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            err <= err_fire;
            if (err_fire) err_code <= err_code_n;
        end
    end

endmodule

// File: tb/tb_pb_field_tokenizer.sv
// Directed self-checking bench for pb_field_tokenizer with hand-computed tokens and errors.
module tb_pb_field_tokenizer;

    typedef struct packed {
        logic [1:0]  kind;
        logic [28:0] field;
        logic [2:0]  wt;
        logic [63:0] value;
        logic        last;
    } tok_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [28:0] out_field;
    logic [2:0]  out_wire;
    logic [63:0] out_value;
    logic        out_last;
    logic        err;
    logic [2:0]  err_code;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   stall_en = 0;
    bit   err_prev = 0;
    int   err_wide = 0;
    tok_t tok_q[$];
    logic [2:0] err_q[$];

    pb_field_tokenizer #(.MAX_LEN(65535)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_field (out_field),
        .out_wire  (out_wire),
        .out_value (out_value),
        .out_last  (out_last),
        .err       (err),
        .err_code  (err_code)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            tok_q.push_back('{out_kind, out_field, out_wire, out_value, out_last});
        if (err) err_q.push_back(err_code);
        if (err && err_prev) err_wide++;
        err_prev = err;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok = 0;
        in_valid = 1; in_data = d; in_last = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0; in_last = 0;
        if (!ok) check("send timeout", 0, 1);
    endtask

    task automatic settle();
        stall_en = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic expect_tok(input string tag, input logic [1:0] kind, input logic [28:0] field,
                              input logic [2:0] wt, input logic [63:0] value, input logic last);
        tok_t t;
        if (tok_q.size() == 0) begin
            check({tag, " present"}, 0, 1);
            return;
        end
        t = tok_q.pop_front();
        check({tag, " kind"},  64'(t.kind),  64'(kind));
        check({tag, " field"}, 64'(t.field), 64'(field));
        check({tag, " wire"},  64'(t.wt),    64'(wt));
        check({tag, " value"}, t.value,      value);
        check({tag, " last"},  64'(t.last),  64'(last));
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        if (err_q.size() == 0) begin
            check({tag, " err pulse"}, 0, 1);
            return;
        end
        check({tag, " err code"}, 64'(err_q.pop_front()), 64'(code));
        check({tag, " err_code held"}, 64'(err_code), 64'(code));
    endtask

    task automatic send_msg3();
        send(8'h08, 0); send(8'h96, 0); send(8'h01, 0);
        send(8'h12, 0); send(8'h02, 0); send(8'h61, 0); send(8'h62, 0);
        send(8'h2D, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    endtask

    task automatic expect_msg3(input string tag);
        expect_tok({tag, " t0"}, 2'd0, 29'd1, 3'd0, 64'd150, 0);
        expect_tok({tag, " t1"}, 2'd1, 29'd2, 3'd2, 64'd2, 0);
        expect_tok({tag, " t2"}, 2'd2, 29'd2, 3'd2, 64'h61, 0);
        expect_tok({tag, " t3"}, 2'd2, 29'd2, 3'd2, 64'h62, 0);
        expect_tok({tag, " t4"}, 2'd0, 29'd5, 3'd5, 64'h04030201, 1);
        check({tag, " extra tokens"}, 64'(tok_q.size()), 0);
    endtask

    initial begin
        in_valid = 0; in_data = 0; in_last = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 0);
        check("reset out_valid", 64'(out_valid), 0);
        check("reset err_code", 64'(err_code), 0);
        check("reset out_value", out_value, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("idle in_ready", 64'(in_ready), 1);

        // varint 150, plus latency-1 check right after the completing byte
        send(8'h08, 0); send(8'h96, 0); send(8'h01, 1);
        check("varint latency valid", 64'(out_valid), 1);
        check("varint latency value", out_value, 64'd150);
        settle();
        expect_tok("varint150", 2'd0, 29'd1, 3'd0, 64'd150, 1);

        send(8'h12, 0); send(8'h02, 0); send(8'h61, 0); send(8'h62, 1);
        settle();
        expect_tok("len hdr", 2'd1, 29'd2, 3'd2, 64'd2, 0);
        expect_tok("pay0", 2'd2, 29'd2, 3'd2, 64'h61, 0);
        expect_tok("pay1", 2'd2, 29'd2, 3'd2, 64'h62, 1);

        send(8'h2D, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h08, 0); send(8'h01, 1);
        settle();
        expect_tok("fixed32", 2'd0, 29'd5, 3'd5, 64'h04030201, 0);
        expect_tok("after fixed32", 2'd0, 29'd1, 3'd0, 64'd1, 1);

        // fixed64 little-endian
        send(8'h09, 0);
        for (int i = 1; i <= 8; i++) send(8'(i * 16 + i), i == 8);
        settle();
        expect_tok("fixed64", 2'd0, 29'd1, 3'd1, 64'h8877665544332211, 1);

        send(8'h08, 0);
        for (int i = 0; i < 10; i++) send(8'hFF, 0);
        send(8'h00, 0); send(8'h00, 1);
        settle();
        expect_err("varint long", 3'd1);
        check("varint long tokens", 64'(tok_q.size()), 0);
        send(8'h08, 0); send(8'h96, 0); send(8'h01, 1);
        settle();
        expect_tok("post-drain", 2'd0, 29'd1, 3'd0, 64'd150, 1);

        send(8'h0B, 0); send(8'h00, 1);
        settle();
        expect_err("wire3", 3'd3);
        check("wire3 tokens", 64'(tok_q.size()), 0);

        send(8'h12, 0); send(8'h05, 0); send(8'h61, 1);
        settle();
        expect_tok("trunc hdr", 2'd1, 29'd2, 3'd2, 64'd5, 0);
        expect_err("trunc", 3'd5);
        check("trunc tokens", 64'(tok_q.size()), 0);

        // 65536 exceeds MAX_LEN by one
        send(8'h12, 0); send(8'h80, 0); send(8'h80, 0); send(8'h04, 0); send(8'h00, 1);
        settle();
        expect_err("len over", 3'd4);
        check("len over tokens", 64'(tok_q.size()), 0);

        send(8'h12, 0); send(8'h00, 1);
        settle();
        expect_tok("len zero", 2'd1, 29'd2, 3'd2, 64'd0, 1);

        // field 0 with in_last on the faulting byte returns straight to key parsing
        send(8'h00, 1);
        send(8'h08, 0); send(8'h01, 1);
        settle();
        expect_err("field0", 3'd2);
        expect_tok("after field0", 2'd0, 29'd1, 3'd0, 64'd1, 1);

        send(8'h08, 0); send(8'h96, 0);
        rst_n = 0;
        #1;
        check("mid-field reset in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        send(8'h08, 0); send(8'h01, 1);
        settle();
        expect_tok("after reset", 2'd0, 29'd1, 3'd0, 64'd1, 1);

        send_msg3();
        settle();
        expect_msg3("nostall");

        stall_en = 1;
        send_msg3();
        settle();
        expect_msg3("stall");

        check("err pulse width", 64'(err_wide), 0);
        check("stray err", 64'(err_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
